// File: rtl/alu_pkg.sv
// Shared ALU definitions: op codes, mul/div FSM states and the
// magnitude/sign helper used by the multiply/divide unit.
package alu_pkg;

   // Widest operand the magnitude helper supports (WIDTH must stay below).
   localparam int MAXW = 128;

   localparam logic [4:0] ALU_ADD   = 5'h00;
   localparam logic [4:0] ALU_SUB   = 5'h01;
   localparam logic [4:0] ALU_AND   = 5'h02;
   localparam logic [4:0] ALU_OR    = 5'h03;
   localparam logic [4:0] ALU_XOR   = 5'h04;
   localparam logic [4:0] ALU_NOR   = 5'h05;
   localparam logic [4:0] ALU_SLT   = 5'h06;
   localparam logic [4:0] ALU_SLTU  = 5'h07;
   localparam logic [4:0] ALU_SLL   = 5'h08;
   localparam logic [4:0] ALU_SRL   = 5'h09;
   localparam logic [4:0] ALU_SRA   = 5'h0A;
   localparam logic [4:0] ALU_LUI   = 5'h0B;
   localparam logic [4:0] ALU_MULT  = 5'h10;
   localparam logic [4:0] ALU_MULTU = 5'h11;
   localparam logic [4:0] ALU_DIV   = 5'h12;
   localparam logic [4:0] ALU_DIVU  = 5'h13;
   localparam logic [4:0] ALU_MTHI  = 5'h14;
   localparam logic [4:0] ALU_MTLO  = 5'h15;
   localparam logic [4:0] ALU_MFHI  = 5'h16;
   localparam logic [4:0] ALU_MFLO  = 5'h17;

   typedef enum logic [1:0] {IDLE, MUL, DIV} muldiv_state_e;

   typedef struct packed {
      logic            neg;
      logic [MAXW-1:0] mag;
   } abs_sign_t;

   // x arrives already sign- or zero-extended to MAXW bits, so the low
   // WIDTH bits of the magnitude are exact even for the most-negative value.
   function automatic abs_sign_t abs_sign(input logic [MAXW-1:0] x);
      abs_sign_t r;
      r.neg = x[MAXW-1];
      r.mag = r.neg ? (~x + 1'b1) : x;
      return r;
   endfunction

endpackage

// File: rtl/muldiv_iter.sv
// Shared radix-2 shift-add / restoring-divide datapath with step counter.
// Ports: clk, resetn, i_load (latch magnitudes), i_step (iterate),
// i_is_div (divide select), i_a/i_b magnitudes, o_last (final step),
// o_hi_nxt/o_lo_nxt (value after the current step).
module muldiv_iter #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             i_load,
   input  logic             i_step,
   input  logic             i_is_div,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_last,
   output logic [WIDTH-1:0] o_hi_nxt,
   output logic [WIDTH-1:0] o_lo_nxt
);

   logic [WIDTH-1:0] r_acc;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] r_b;
   logic [CNT_W-1:0] r_cnt;

   logic [WIDTH:0]   w_sum;
   logic [WIDTH:0]   w_diff;
   logic [WIDTH-1:0] w_sh;

   assign w_sum  = {1'b0, r_acc} + (r_q[0] ? {1'b0, r_b} : '0);
   assign w_sh   = {r_acc[WIDTH-2:0], r_q[WIDTH-1]};
   assign w_diff = {r_acc[WIDTH-1], w_sh} - {1'b0, r_b};
   assign o_last = (r_cnt == CNT_W'(WIDTH-1));

   always_comb begin
      o_hi_nxt = r_acc;
      o_lo_nxt = r_q;
      if (i_is_div) begin
         // Borrow bit clear means the trial subtraction fits.
         if (!w_diff[WIDTH]) begin
            o_hi_nxt = w_diff[WIDTH-1:0];
            o_lo_nxt = {r_q[WIDTH-2:0], 1'b1};
         end else begin
            o_hi_nxt = w_sh;
            o_lo_nxt = {r_q[WIDTH-2:0], 1'b0};
         end
      end else begin
         o_hi_nxt = w_sum[WIDTH:1];
         o_lo_nxt = {w_sum[0], r_q[WIDTH-1:1]};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_acc <= '0;
         r_q   <= '0;
         r_b   <= '0;
         r_cnt <= '0;
      end else if (i_load) begin
         r_acc <= '0;
         r_q   <= i_a;
         r_b   <= i_b;
         r_cnt <= '0;
      end else if (i_step) begin
         r_acc <= o_hi_nxt;
         r_q   <= o_lo_nxt;
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/alu_muldiv.sv
// Multi-cycle multiply/divide unit owning the architectural HI/LO pair.
// Ports: clk, resetn, start, op, a, b, cancel in; busy, done, hi, lo out.
// ALU_MULDIV_FAST_MUL_EN selects a single-cycle array multiplier.
module alu_muldiv
   import alu_pkg::*;
#(
   parameter  int WIDTH = 32,
   localparam int CNT_W = $clog2(WIDTH+1)
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [4:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cancel,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   muldiv_state_e r_state, w_state_nxt;

   logic [WIDTH-1:0] r_hi, r_lo, r_a;
   logic r_done, r_neg_q, r_neg_r, r_dz;

   logic w_is_mul, w_is_div, w_signed, w_go, w_fin;
   logic w_it_mul, w_load, w_last, w_neg_a, w_neg_b;
   logic [WIDTH-1:0] w_mag_a, w_mag_b, w_hi_nxt, w_lo_nxt;
   logic [WIDTH-1:0] w_quot, w_rem;
   logic [2*WIDTH-1:0] w_prod;
   logic [MAXW-WIDTH-1:0] w_unused_a, w_unused_b;
   abs_sign_t w_abs_a, w_abs_b;

   assign w_is_mul = (op == ALU_MULT) | (op == ALU_MULTU);
   assign w_is_div = (op == ALU_DIV) | (op == ALU_DIVU);
   assign w_signed = (op == ALU_MULT) | (op == ALU_DIV);
   assign w_go     = start & ~cancel & (r_state == IDLE);

   assign w_abs_a = abs_sign({{(MAXW-WIDTH){w_signed & a[WIDTH-1]}}, a});
   assign w_abs_b = abs_sign({{(MAXW-WIDTH){w_signed & b[WIDTH-1]}}, b});
   assign {w_unused_a, w_mag_a} = w_abs_a.mag;
   assign {w_unused_b, w_mag_b} = w_abs_b.mag;
   assign w_neg_a = w_abs_a.neg;
   assign w_neg_b = w_abs_b.neg;

`ifdef ALU_MULDIV_FAST_MUL_EN
   logic [2*WIDTH-1:0] w_fast;
   assign w_it_mul = 1'b0;
   assign w_fast   = {{WIDTH{1'b0}}, w_mag_a} * {{WIDTH{1'b0}}, w_mag_b};
`else
   assign w_it_mul = w_is_mul;
`endif

   assign w_load = w_go & (w_it_mul | w_is_div);
   assign w_fin  = (r_state != IDLE) & ~cancel & w_last;

   muldiv_iter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_iter (
      .clk      (clk),
      .resetn   (resetn),
      .i_load   (w_load),
      .i_step   (r_state != IDLE),
      .i_is_div (r_state == DIV),
      .i_a      (w_mag_a),
      .i_b      (w_mag_b),
      .o_last   (w_last),
      .o_hi_nxt (w_hi_nxt),
      .o_lo_nxt (w_lo_nxt)
   );

   assign w_prod = r_neg_q ? -{w_hi_nxt, w_lo_nxt} : {w_hi_nxt, w_lo_nxt};
   assign w_quot = r_neg_q ? -w_lo_nxt : w_lo_nxt;
   assign w_rem  = r_neg_r ? -w_hi_nxt : w_hi_nxt;

   always_comb begin
      w_state_nxt = r_state;
      unique case (r_state)
         IDLE: begin
            if (w_go & w_it_mul) w_state_nxt = MUL;
            else if (w_go & w_is_div) w_state_nxt = DIV;
         end
         MUL, DIV: begin
            if (cancel | w_last) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) r_state <= IDLE;
      else         r_state <= w_state_nxt;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_hi    <= '0;
         r_lo    <= '0;
         r_a     <= '0;
         r_done  <= 1'b0;
         r_neg_q <= 1'b0;
         r_neg_r <= 1'b0;
         r_dz    <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_go & (op == ALU_MTHI)) r_hi <= a;
         if (w_go & (op == ALU_MTLO)) r_lo <= a;
         if (w_load) begin
            r_neg_q <= w_neg_a ^ w_neg_b;
            r_neg_r <= w_neg_a;
            r_dz    <= (b == '0);
            r_a     <= a;
         end
`ifdef ALU_MULDIV_FAST_MUL_EN
         if (w_go & w_is_mul) begin
            {r_hi, r_lo} <= (w_neg_a ^ w_neg_b) ? -w_fast : w_fast;
            r_done       <= 1'b1;
         end
`endif
         if (w_fin) begin
            r_done <= 1'b1;
            if (r_state == MUL) begin
               {r_hi, r_lo} <= w_prod;
            end else if (r_dz) begin
               // Divide by zero leaves the raw dividend in HI.
               r_hi <= r_a;
               r_lo <= '1;
            end else begin
               r_hi <= w_rem;
               r_lo <= w_quot;
            end
         end
      end
   end

   assign busy = (r_state != IDLE);
   assign done = r_done;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Multi-cycle multiply/divide unit with architectural HI/LO registers, parametrised in operand width.
- Sits in EX beside the combinational ALU and serves MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- The ALU reads HI/LO for MFHI/MFLO through the hi/lo outputs.
- The pipeline stalls while busy is high.

Parameters:
- WIDTH, 32, operand width and HI/LO width; must be even and >= 4.
- CNT_W, $clog2(WIDTH+1), iteration counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock
- resetn  input  1  asynchronous active-low reset
- start  input  1  request, sampled at the rising edge
- op  input  5  operation code, same encoding as the ALU op field (MULT/MULTU/DIV/DIVU/MTHI/MTLO)
- a  input  WIDTH  rs operand (multiplicand/dividend; MTHI/MTLO source)
- b  input  WIDTH  rt operand (multiplier/divisor)
- cancel  input  1  abort in-flight operation (exception/flush)
- busy  output  1  iterative operation in flight; pipeline stall request
- done  output  1  one-cycle pulse when HI/LO take a mul/div result
- hi  output  WIDTH  HI register
- lo  output  WIDTH  LO register

Behaviour:
- Reset (resetn low, asynchronous): hi=0, lo=0, busy=0, done=0, state IDLE, counter=0.
- States:
  - IDLE: busy=0.
  - MUL: WIDTH iterations.
  - DIV: WIDTH iterations.
- Request acceptance: start is accepted only in IDLE with cancel=0. start while busy is ignored (no queueing). start with an undefined op is ignored.
- MTHI/MTLO: the accepted edge writes hi<=a (or lo<=a); one-cycle latency, no busy, no done.
- MULT/MULTU:
  - Accepted edge latches the operands. Signed ops take the magnitudes and record the result sign (a[W-1]^b[W-1]).
  - Radix-2 shift-add: one partial product per cycle.
  - busy=1 for exactly WIDTH cycles.
  - On the WIDTH-th edge after acceptance: {hi,lo} <= sign-corrected 2*WIDTH-bit product, done=1 for one cycle, busy=0, back to IDLE.
- DIV/DIVU:
  - Restoring division on magnitudes, one quotient bit per cycle, same timing as MUL.
  - lo <= quotient; hi <= remainder.
  - Signed: the quotient is negated if the operand signs differ; the remainder takes the dividend's sign.
- Boundary cases:
  - Divide by zero: completes with normal latency; lo = all ones, hi = a (unmodified dividend, both signed and unsigned).
  - Signed overflow (a = -2^(W-1), b = -1): lo = -2^(W-1), hi = 0.
  - Most-negative magnitude: handled in WIDTH bits unsigned, no loss.
- cancel:
  - When busy: aborts at the next edge; hi/lo unchanged, no done, busy=0, IDLE.
  - When idle: suppresses a simultaneous start, including MTHI/MTLO.
  - cancel on the completing edge wins: no write, no done.
- Reset mid-operation: immediate return to reset values; the partial result is discarded.
- done is never high in the same cycle as busy.

Optional Feature:
- Macro: ALU_MULDIV_FAST_MUL_EN.
- Defined: MULT/MULTU use a single-cycle array product. The accepted edge writes {hi,lo} and pulses done, busy never asserts, and cancel has no effect.
- Undefined: iterative multiplier, WIDTH cycles as above.
- Division is always iterative.

Decomposition:
- Shared package alu_pkg:
  - op code constants (ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MTHI, ALU_MTLO, plus the existing ALU_* codes);
  - typedef muldiv_state_e {IDLE, MUL, DIV};
  - helper function abs_sign for magnitude/sign extraction.
- One natural sub-module, muldiv_iter: shared shift/add-subtract datapath and counter, with an is_div select.
- alu_muldiv keeps the FSM, sign correction, HI/LO and cancel handling.

Test Plan:
- MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy 32 cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT a=-7 (0xFFFFFFF9) b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; repeat with ALU_MULDIV_FAST_MUL_EN -> same values, done on the accept edge, busy never high.
- DIV a=-7 b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1); DIVU a=7 b=0 -> lo=0xFFFFFFFF, hi=7.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0; then MTHI a=0x1234 -> hi=0x1234 next cycle, busy stays 0.
- DIVU 100/7 started, cancel at cycle 10 -> busy low next cycle, no done, hi/lo keep prior values; a start during busy is ignored.
- Assert resetn low at cycle 5 of a MULT -> hi=lo=0, busy=0 immediately; WIDTH=16 instance MULTU 0xFFFF*0x0002 -> hi=0x0001, lo=0xFFFE after 16 cycles.
